// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM test harnesses: FSM state type and default geometry.
package lutram_test_pkg;

  localparam int unsigned AWidthDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCheck = 2'b01,
    StDone  = 2'b10
  } lutram_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops once its MSB is set, i.e. at 2**(WIDTH-1).
module sat_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !cnt_q[WIDTH-1]) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lutram_read_checker.sv
// Checks a full-depth LUTRAM read sweep against the alternating addr[0] pattern and
// reports data mismatches, the first failing address and out-of-order addressing.
module lutram_read_checker
  import lutram_test_pkg::*;
#(
  parameter int unsigned A_WIDTH = AWidthDefault,
  parameter bit          INVERT  = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic               q_i,
  output logic               done_o,
  output logic               pass_o,
  output logic [A_WIDTH:0]   err_count_o,
  output logic               seq_err_o,
  output logic [A_WIDTH-1:0] first_err_addr_o,
  output logic               first_err_vld_o
);

  lutram_state_e      state_q, state_d;
  logic [A_WIDTH-1:0] exp_addr_q, exp_addr_d;
  logic               seq_err_q, seq_err_d;
  logic [A_WIDTH-1:0] ferr_addr_q, ferr_addr_d;
  logic               ferr_vld_q, ferr_vld_d;

  logic beat;
  logic exp_bit;
  logic data_err;

  // A start pulse always wins over a coincident beat.
  assign beat     = (state_q == StCheck) && valid_i && !start_i;
  assign exp_bit  = addr_i[0] ^ INVERT;
  assign data_err = beat && (q_i != exp_bit);

  always_comb begin
    state_d     = state_q;
    exp_addr_d  = exp_addr_q;
    seq_err_d   = seq_err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_vld_d  = ferr_vld_q;

    if (start_i) begin
      state_d     = StCheck;
      exp_addr_d  = '0;
      seq_err_d   = 1'b0;
      ferr_addr_d = '0;
      ferr_vld_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StCheck: begin
          if (beat) begin
            exp_addr_d = exp_addr_q + A_WIDTH'(1);
            if (addr_i != exp_addr_q) begin
              seq_err_d = 1'b1;
            end
            if (data_err && !ferr_vld_q) begin
              ferr_addr_d = addr_i;
              ferr_vld_d  = 1'b1;
            end
            if (exp_addr_q == '1) begin
              state_d = StDone;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      exp_addr_q  <= '0;
      seq_err_q   <= 1'b0;
      ferr_addr_q <= '0;
      ferr_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_addr_q  <= exp_addr_d;
      seq_err_q   <= seq_err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_vld_q  <= ferr_vld_d;
    end
  end

  sat_counter #(
    .WIDTH (A_WIDTH + 1)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (start_i),
    .inc    (data_err),
    .cnt    (err_count_o)
  );

  // Outputs decode registered state only; no input reaches them combinationally.
  assign done_o           = (state_q == StDone);
  assign pass_o           = done_o && (err_count_o == '0) && !seq_err_q;
  assign seq_err_o        = seq_err_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_vld_o  = ferr_vld_q;

endmodule

// File: tb/tb_lutram_read_checker.sv
// Randomized bench: two checkers (INVERT=0 and INVERT=1) share one stimulus stream and are
// compared every cycle against a per-beat reference model.
module tb_lutram_read_checker;

  localparam int Depth = 256;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       q = 1'b0;
  logic [7:0] addr = '0;

  logic       done0, pass0, seq0, fvld0;
  logic [8:0] err0;
  logic [7:0] faddr0;
  logic       done1, pass1, seq1, fvld1;
  logic [8:0] err1;
  logic [7:0] faddr1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  int m_err[2];
  int m_first[2];
  bit m_fvld[2];
  bit m_seq;
  int m_next;
  bit m_checking;
  bit m_done;

  always #5 clk = ~clk;

  lutram_read_checker #(.A_WIDTH(8), .INVERT(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .valid_i(valid), .addr_i(addr), .q_i(q),
    .done_o(done0), .pass_o(pass0), .err_count_o(err0), .seq_err_o(seq0),
    .first_err_addr_o(faddr0), .first_err_vld_o(fvld0)
  );

  lutram_read_checker #(.A_WIDTH(8), .INVERT(1'b1)) dut_inv (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .valid_i(valid), .addr_i(addr), .q_i(q),
    .done_o(done1), .pass_o(pass1), .err_count_o(err1), .seq_err_o(seq1),
    .first_err_addr_o(faddr1), .first_err_vld_o(fvld1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_err[k]   = 0;
      m_first[k] = 0;
      m_fvld[k]  = 1'b0;
    end
    m_seq  = 1'b0;
    m_next = 0;
    m_done = 1'b0;
  endtask

  task automatic cmp_dut(input int k, input logic d, input logic p, input logic [8:0] e,
                         input logic s, input logic [7:0] fa, input logic fv);
    bit exp_pass;
    exp_pass = m_done && (m_err[k] == 0) && !m_seq;
    check($sformatf("dut%0d.done", k), 32'(d), 32'(m_done));
    check($sformatf("dut%0d.pass", k), 32'(p), 32'(exp_pass));
    check($sformatf("dut%0d.err_count", k), 32'(e), 32'(m_err[k]));
    check($sformatf("dut%0d.seq_err", k), 32'(s), 32'(m_seq));
    check($sformatf("dut%0d.first_err_addr", k), 32'(fa), 32'(m_first[k]));
    check($sformatf("dut%0d.first_err_vld", k), 32'(fv), 32'(m_fvld[k]));
  endtask

  task automatic compare_all();
    cmp_dut(0, done0, pass0, err0, seq0, faddr0, fvld0);
    cmp_dut(1, done1, pass1, err1, seq1, faddr1, fvld1);
  endtask

  // Drive one cycle of inputs, update the model on the sampling edge, then compare.
  task automatic drive(input bit v, input int a, input bit qq, input bit st);
    start = st;
    valid = v;
    addr  = 8'(a);
    q     = qq;
    @(posedge clk);
    if (st) begin
      model_clear();
      m_checking = 1'b1;
    end else if (v && m_checking) begin
      for (int k = 0; k < 2; k++) begin
        if (qq != ((a % 2) ^ k)) begin
          m_err[k] = (m_err[k] < Depth) ? m_err[k] + 1 : Depth;
          if (!m_fvld[k]) begin
            m_fvld[k]  = 1'b1;
            m_first[k] = a % Depth;
          end
        end
      end
      if ((a % Depth) != m_next) m_seq = 1'b1;
      if (m_next == Depth - 1) begin
        m_checking = 1'b0;
        m_done     = 1'b1;
      end
      m_next = (m_next + 1) % Depth;
    end
    #1;
    start = 1'b0;
    valid = 1'b0;
    compare_all();
  endtask

  task automatic do_start();
    // valid is high with a random payload to show it is ignored under start
    drive(1'b1, $urandom_range(255), 1'($urandom), 1'b1);
  endtask

  // mode 0: clean, 1: flips at 17 and 200, 2: addr 5 repeated, 3: random flips
  task automatic run_pass(input int mode, input int n_beats = 256);
    int a;
    bit f;
    for (int i = 0; i < n_beats; i++) begin
      while ($urandom_range(3) == 0) drive(1'b0, $urandom_range(255), 1'($urandom), 1'b0);
      a = (mode == 2 && i >= 6) ? i - 1 : i;
      f = (mode == 1 && (a == 17 || a == 200)) || (mode == 3 && $urandom_range(15) == 0);
      drive(1'b1, a, 1'(a % 2) ^ f, 1'b0);
    end
  endtask

  task automatic ignored_beats(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, $urandom_range(255), 1'($urandom), 1'b0);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    start  = 1'b0;
    valid  = 1'b0;
    #2;
    model_clear();
    m_checking = 1'b0;
    compare_all();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    compare_all();
  endtask

  initial begin
    model_clear();
    m_checking = 1'b0;
    #2;
    compare_all();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    ignored_beats(4);

    // Clean sweep; the inverted checker sees every beat as an error and saturates.
    do_start();
    run_pass(0);
    check("clean.done", 32'(done0), 1);
    check("clean.pass", 32'(pass0), 1);
    check("clean.err", 32'(err0), 0);
    check("sat.err", 32'(err1), 256);
    check("sat.first_addr", 32'(faddr1), 0);
    check("sat.pass", 32'(pass1), 0);
    ignored_beats(4);

    do_start();
    run_pass(1);
    check("flip.err", 32'(err0), 2);
    check("flip.first_addr", 32'(faddr0), 17);
    check("flip.first_vld", 32'(fvld0), 1);
    check("flip.pass", 32'(pass0), 0);
    check("flip_inv.err", 32'(err1), 254);

    do_start();
    run_pass(2);
    check("seq.seq_err", 32'(seq0), 1);
    check("seq.done", 32'(done0), 1);
    check("seq.pass", 32'(pass0), 0);
    check("seq.err", 32'(err0), 0);

    do_start();
    run_pass(0, 100);
    apply_reset();
    check("rst.done", 32'(done0), 0);
    check("rst.err_inv", 32'(err1), 0);
    ignored_beats(3);
    check("rst.idle_err_inv", 32'(err1), 0);
    do_start();
    run_pass(0);
    check("rst.clean_pass", 32'(pass0), 1);

    // Restart from DONE: results cleared in the cycle after start.
    do_start();
    check("restart.err_inv", 32'(err1), 0);
    check("restart.first_vld_inv", 32'(fvld1), 0);
    check("restart.done", 32'(done0), 0);
    run_pass(0);
    check("restart.pass", 32'(pass0), 1);

    // Restart mid-check, then a pass with random data errors.
    do_start();
    run_pass(3, 50);
    do_start();
    run_pass(3);
    check("rand.done", 32'(done0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lutram_read_checker.md
LUTRAM_READ_CHECKER -- requirements
Module: lutram_read_checker

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8, RAM address width; depth is 2**A_WIDTH.
REQ-002 SHALL have parameter INVERT, default 0; when 1, the expected pattern is inverted.
REQ-003 SHALL have port clk_i  input  1  test clock, the same divided clock that drives the RAM WCLK.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle pulse that begins a check pass.
REQ-006 SHALL have port valid_i  input  1  read beat is present this cycle.
REQ-007 SHALL have port addr_i  input  A_WIDTH  address of the read beat.
REQ-008 SHALL have port q_i  input  1  asynchronous RAM read data for addr_i.
REQ-009 SHALL have port done_o  output  1  pass complete; results are stable.
REQ-010 SHALL have port pass_o  output  1  done with zero data errors and zero sequence errors.
REQ-011 SHALL have port err_count_o  output  A_WIDTH+1  count of data mismatches.
REQ-012 SHALL have port seq_err_o  output  1  sticky flag: an address arrived out of order.
REQ-013 SHALL have port first_err_addr_o  output  A_WIDTH  addr_i of the first data mismatch.
REQ-014 SHALL have port first_err_vld_o  output  1  first_err_addr_o holds a valid address.

Function
REQ-015 SHALL implement the FSM states IDLE, CHECK and DONE; any illegal encoding SHALL go to IDLE.
REQ-016 SHALL move IDLE->CHECK on start_i, and on that edge SHALL clear the expected-address counter, err_count_o, seq_err_o, first_err_vld_o and first_err_addr_o.
REQ-017 SHALL treat start_i in CHECK or DONE as a restart: same clears, next state CHECK.
REQ-018 SHALL ignore valid_i in IDLE, in DONE, and in any cycle where start_i is high.
REQ-019 SHALL compute expected data for each beat in CHECK as addr_i[0] XOR INVERT.
REQ-020 SHALL count a data error when q_i differs from the expected data on a beat.
REQ-021 SHALL set seq_err_o when addr_i differs from the expected-address counter on a beat; the counter SHALL still advance by 1 per beat.
REQ-022 SHALL update err_count_o, seq_err_o and first_err_* on the clock edge that samples the beat, i.e. one-cycle latency.
REQ-023 SHALL saturate err_count_o at 2**A_WIDTH; no wrap-around is permitted.
REQ-024 SHALL capture first_err_addr_o only on the first data error of a pass; later errors SHALL leave it unchanged.
REQ-025 SHALL move CHECK->DONE on the edge that accepts the beat where the expected-address counter equals 2**A_WIDTH-1; the counter SHALL wrap to 0.
REQ-026 SHALL assert done_o in DONE only, with all result outputs final in the same cycle.
REQ-027 SHALL drive pass_o = done_o AND err_count_o==0 AND NOT seq_err_o.
REQ-028 SHALL allow gaps of arbitrary length between beats (valid_i low); gaps SHALL cause no state change.

Reset
REQ-029 SHALL, on rst_ni low, immediately force: state IDLE, counter 0, done_o 0, pass_o 0, err_count_o 0, seq_err_o 0, first_err_addr_o 0, first_err_vld_o 0.
REQ-030 SHALL abandon a pass cleanly when reset is asserted mid-CHECK; after release the block SHALL wait in IDLE for start_i.
REQ-031 SHALL leave all outputs registered, with no combinational path from any input to any output.

Structure
REQ-032 SHALL take the state enum and the A_WIDTH default from the shared package lutram_test_pkg, which is also used by the other LUTRAM test harnesses.
REQ-033 SHALL place the saturating error counter in a sub-module sat_counter (parameter WIDTH; ports clr, inc, cnt); all other logic SHALL be flat.

Verification
REQ-034 SHALL cover a clean pass: start_i, then 256 beats with addr 0..255 and q=addr[0] -> done_o=1 one cycle after beat 255, pass_o=1, err_count_o=0.
REQ-035 SHALL cover single-bit errors: flip q at addr 17 and addr 200 -> err_count_o=2, first_err_addr_o=17, first_err_vld_o=1, pass_o=0.
REQ-036 SHALL cover saturation: INVERT=1 with q=addr[0] at every beat -> err_count_o=256 (no wrap), first_err_addr_o=0.
REQ-037 SHALL cover a sequence error: addr 5 sent twice, then the sequence continues -> seq_err_o=1, DONE after 256 beats, pass_o=0, err_count_o=0.
REQ-038 SHALL cover reset mid-pass: rst_ni low after 100 beats -> all outputs 0 and state IDLE; start_i then a clean pass -> pass_o=1.
REQ-039 SHALL cover restart and gaps: start_i in DONE, then beats with random valid_i gaps -> result counters cleared in the cycle after start_i; clean result at end.
